// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the two-port ALU share arbiter.
// The state encoding and ALUFun codes are used by the RTL and by the testbench.
package alu_arb_pkg;

    typedef logic [1:0] state_t;

    localparam state_t S_IDLE = 2'd0;
    localparam state_t S_EXEC = 2'd1;
    localparam state_t S_RESP = 2'd2;

    // ALUFun codes: [5:4] selects the unit, the low bits select the operation within it
    localparam logic [5:0] ADD = 6'b000000;
    localparam logic [5:0] SUB = 6'b000001;
    localparam logic [5:0] AND = 6'b011000;
    localparam logic [5:0] OR  = 6'b011110;
    localparam logic [5:0] XOR = 6'b010110;
    localparam logic [5:0] NOR = 6'b010001;
    localparam logic [5:0] LDA = 6'b011010;
    localparam logic [5:0] SLL = 6'b100000;
    localparam logic [5:0] SRL = 6'b100001;
    localparam logic [5:0] SRA = 6'b100011;
    localparam logic [5:0] EQ  = 6'b110011;
    localparam logic [5:0] NEQ = 6'b110001;
    localparam logic [5:0] LT  = 6'b110101;
    localparam logic [5:0] LEZ = 6'b111101;
    localparam logic [5:0] LTZ = 6'b111011;
    localparam logic [5:0] GTZ = 6'b111111;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [5:0]  fun;
        logic        sign;
    } alu_op_t;

endpackage

// File: rtl/alu_share_arbiter_if.sv
// Request/response bundle between the two requesters and the ALU share arbiter.
// master = requester side, slave = arbiter side.
interface alu_share_arbiter_if;

    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [31:0] req_a0;
    logic [31:0] req_a1;
    logic [31:0] req_b0;
    logic [31:0] req_b1;
    logic [5:0]  req_fun0;
    logic [5:0]  req_fun1;
    logic [1:0]  req_sign;
    logic [1:0]  resp_valid;
    logic [1:0]  resp_ready;
    logic [31:0] resp_data;

    modport master (
        output req_valid, req_a0, req_a1, req_b0, req_b1,
               req_fun0, req_fun1, req_sign, resp_ready,
        input  req_ready, resp_valid, resp_data
    );

    modport slave (
        input  req_valid, req_a0, req_a1, req_b0, req_b1,
               req_fun0, req_fun1, req_sign, resp_ready,
        output req_ready, resp_valid, resp_data
    );

endinterface

// File: rtl/ALU_32bits.sv
// Combinational 32-bit ALU: add/sub, logic, shift and compare units selected by ALUFun[5:4].
// Shifts move B by A[4:0]; Sign only affects the LT comparison.
module ALU_32bits (
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [5:0]  ALUFun,
    input  logic        Sign,
    output logic [31:0] ALUOut
);

    logic [31:0] sum;
    logic        lt;
    logic        cmp;

    assign sum = ALUFun[0] ? (A - B) : (A + B);
    assign lt  = Sign ? ($signed(A) < $signed(B)) : (A < B);

    always_comb begin
        cmp = 1'b0;
        case (ALUFun[3:1])
            3'b001:  cmp = (A == B);
            3'b000:  cmp = (A != B);
            3'b010:  cmp = lt;
            3'b110:  cmp = A[31] || (A == 32'd0);
            3'b101:  cmp = A[31];
            3'b111:  cmp = !A[31] && (A != 32'd0);
            default: cmp = 1'b0;
        endcase
    end

    always_comb begin
        ALUOut = 32'd0;
        case (ALUFun[5:4])
            2'b00: ALUOut = sum;
            2'b01: begin
                case (ALUFun[3:0])
                    4'b1000: ALUOut = A & B;
                    4'b1110: ALUOut = A | B;
                    4'b0110: ALUOut = A ^ B;
                    4'b0001: ALUOut = ~(A | B);
                    4'b1010: ALUOut = A;
                    default: ALUOut = 32'd0;
                endcase
            end
            2'b10: begin
                case (ALUFun[1:0])
                    2'b00:   ALUOut = B << A[4:0];
                    2'b01:   ALUOut = B >> A[4:0];
                    2'b11:   ALUOut = $signed(B) >>> A[4:0];
                    default: ALUOut = 32'd0;
                endcase
            end
            default: ALUOut = {31'd0, cmp};
        endcase
    end

endmodule

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant: a lone valid wins outright, a tie goes to rr_ptr.
module rr_arbiter2 (
    input  logic [1:0] valid,
    input  logic       rr_ptr,
    output logic [1:0] grant
);

    always_comb begin
        grant = valid;
        if (valid == 2'b11) begin
            grant         = 2'b00;
            grant[rr_ptr] = 1'b1;
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one ALU_32bits between two requesters: grant in IDLE, compute from latched
// operands in EXEC, hold the registered result in RESP until the owner accepts it.
module alu_share_arbiter
    import alu_arb_pkg::*;
#(
    parameter int CNT_W   = 16,
    parameter int RR_INIT = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    alu_share_arbiter_if.slave   bus,
    output logic                 busy,
    output logic [CNT_W-1:0]     op_count
);

    localparam logic RR_RST = (RR_INIT != 0);

    state_t      state_q, state_d;
    logic        rr_ptr;
    logic        owner_q;
    alu_op_t     op_q, req_op;
    logic [1:0]  grant;
    logic [1:0]  req_ready_c, resp_valid_c;
    logic [31:0] alu_out, resp_data_q;
    logic        take, done;

    rr_arbiter2 u_rr (
        .valid  (bus.req_valid),
        .rr_ptr (rr_ptr),
        .grant  (grant)
    );

    // The ALU only ever sees the latched operands, never the live request buses
    ALU_32bits u_alu (
        .A      (op_q.a),
        .B      (op_q.b),
        .ALUFun (op_q.fun),
        .Sign   (op_q.sign),
        .ALUOut (alu_out)
    );

    assign take = (state_q == S_IDLE) && (grant != 2'b00);
    assign done = (state_q == S_RESP) && bus.resp_ready[owner_q];

    always_comb begin
        if (grant[1])
            req_op = '{a: bus.req_a1, b: bus.req_b1, fun: bus.req_fun1, sign: bus.req_sign[1]};
        else
            req_op = '{a: bus.req_a0, b: bus.req_b0, fun: bus.req_fun0, sign: bus.req_sign[0]};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (take) state_d = S_EXEC;
            S_EXEC:  state_d = S_RESP;
            S_RESP:  if (done) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready_c  = 2'b00;
        resp_valid_c = 2'b00;
        busy         = 1'b0;
        case (state_q)
            S_IDLE: req_ready_c = grant;
            S_EXEC: busy = 1'b1;
            S_RESP: begin
                busy                  = 1'b1;
                resp_valid_c[owner_q] = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.req_ready  = req_ready_c;
    assign bus.resp_valid = resp_valid_c;
    assign bus.resp_data  = resp_data_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_q        <= '0;
            owner_q     <= 1'b0;
            resp_data_q <= 32'd0;
            op_count    <= '0;
            rr_ptr      <= RR_RST;
        end else begin
            if (take) begin
                op_q    <= req_op;
                owner_q <= grant[1];
            end
            if (state_q == S_EXEC)
                resp_data_q <= alu_out;
            // Priority passes to the other port only once a response is consumed
            if (done) begin
                op_count <= op_count + CNT_W'(1);
                rr_ptr   <= ~owner_q;
            end
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: vector table, scoreboard monitor and multi-cycle corner sequences.
module tb_alu_share_arbiter;
    import alu_arb_pkg::*;

    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          busy;
    logic [CW-1:0] op_count;

    always #5 clk = ~clk;

    alu_share_arbiter_if bus ();

    alu_share_arbiter #(.CNT_W(CW), .RR_INIT(0)) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .busy     (busy),
        .op_count (op_count)
    );

    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        int          port;
        logic [31:0] data;
    } sb_t;

    typedef struct {
        int          port;
        logic [31:0] a;
        logic [31:0] b;
        logic [5:0]  fun;
        logic        sign;
        logic [31:0] exp;
    } vec_t;

    sb_t           sbq[$];
    int            grant_log[$];
    logic [CW-1:0] exp_cnt = '0;
    bit            cnt_chk = 0;
    vec_t          vt[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                              input logic [5:0] fun, input logic sign);
        logic lt;
        lt = sign ? ($signed(a) < $signed(b)) : (a < b);
        case (fun)
            ADD:     return a + b;
            SUB:     return a - b;
            AND:     return a & b;
            SLL:     return b << a[4:0];
            EQ:      return {31'd0, a == b};
            LT:      return {31'd0, lt};
            default: return 32'd0;
        endcase
    endfunction

    // Scoreboard: push on each grant handshake, pop on each response handshake
    always @(negedge clk) begin
        if (reset) begin
            if (cnt_chk) begin
                check("op_count", 32'(op_count), 32'(exp_cnt));
                cnt_chk = 0;
            end
            if (bus.req_valid[0] && bus.req_ready[0]) begin
                sbq.push_back('{0, alu_model(bus.req_a0, bus.req_b0, bus.req_fun0, bus.req_sign[0])});
                grant_log.push_back(0);
            end
            if (bus.req_valid[1] && bus.req_ready[1]) begin
                sbq.push_back('{1, alu_model(bus.req_a1, bus.req_b1, bus.req_fun1, bus.req_sign[1])});
                grant_log.push_back(1);
            end
            if (bus.resp_valid != 2'b00) begin
                int o;
                check("resp_valid_onehot", 32'($onehot(bus.resp_valid)), 32'd1);
                check("busy_in_resp", 32'(busy), 32'd1);
                o = bus.resp_valid[1] ? 1 : 0;
                if (bus.resp_ready[o]) begin
                    if (sbq.size() == 0) begin
                        check("sb_underflow", 32'd1, 32'd0);
                    end else begin
                        sb_t e;
                        e = sbq.pop_front();
                        check("sb_owner", 32'(o), 32'(e.port));
                        check("sb_data", bus.resp_data, e.data);
                    end
                    exp_cnt = exp_cnt + 1'b1;
                    cnt_chk = 1;
                end
            end
        end
    end

    task automatic set_bus(input int p, input logic [31:0] a, input logic [31:0] b,
                           input logic [5:0] fun, input logic sign);
        if (p == 0) begin
            bus.req_a0 = a; bus.req_b0 = b; bus.req_fun0 = fun; bus.req_sign[0] = sign;
        end else begin
            bus.req_a1 = a; bus.req_b1 = b; bus.req_fun1 = fun; bus.req_sign[1] = sign;
        end
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        bus.req_valid = 2'b00;
        sbq.delete();
        grant_log.delete();
        exp_cnt = '0;
        cnt_chk = 0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    task automatic wait_grant(input int p);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.req_ready[p] && n < 30);
        check("grant_seen", 32'(bus.req_ready[p]), 32'd1);
        check("grant_onehot", 32'(bus.req_ready), 32'(2'b01 << p));
    endtask

    task automatic wait_resp(input int p, output int lat, output logic [31:0] data);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!bus.resp_valid[p] && lat < 30);
        check("resp_seen", 32'(bus.resp_valid[p]), 32'd1);
        data = bus.resp_data;
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((sbq.size() != 0 || busy) && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("drain", 32'(sbq.size()), 32'd0);
    endtask

    task automatic do_op(input vec_t v, output int lat, output logic [31:0] data);
        @(posedge clk);
        #1;
        set_bus(v.port, v.a, v.b, v.fun, v.sign);
        bus.req_valid[v.port] = 1'b1;
        wait_grant(v.port);
        @(posedge clk);
        #1 bus.req_valid[v.port] = 1'b0;
        wait_resp(v.port, lat, data);
    endtask

    initial begin
        int          lat;
        logic [31:0] d;

        vt[0] = '{0, 32'd5,        32'd7,        ADD, 1'b1, 32'd12};
        vt[1] = '{1, 32'd10,       32'd3,        SUB, 1'b1, 32'd7};
        vt[2] = '{0, 32'hF0F0F0F0, 32'h0FF0FFFF, AND, 1'b0, 32'h00F0F0F0};
        vt[3] = '{1, 32'd4,        32'd1,        SLL, 1'b0, 32'd16};
        vt[4] = '{0, 32'd3,        32'd3,        EQ,  1'b0, 32'd1};
        vt[5] = '{1, 32'hFFFFFFFF, 32'd1,        LT,  1'b1, 32'd1};
        vt[6] = '{0, 32'hFFFFFFFF, 32'd1,        LT,  1'b0, 32'd0};
        vt[7] = '{1, 32'd0,        32'd1,        SUB, 1'b1, 32'hFFFFFFFF};
        vt[8] = '{0, 32'hFFFFFFFF, 32'd1,        ADD, 1'b0, 32'd0};

        bus.req_valid  = 2'b00;
        bus.resp_ready = 2'b11;
        set_bus(0, '0, '0, ADD, 1'b0);
        set_bus(1, '0, '0, ADD, 1'b0);

        apply_reset();
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        check("rst_resp_data", bus.resp_data, 32'd0);
        check("rst_op_count", 32'(op_count), 32'd0);
        check("rst_req_ready", 32'(bus.req_ready), 32'd0);

        // Vector table: one op at a time, latency 2 and op_count wrapping modulo 4
        for (int i = 0; i < 9; i++) begin
            logic [CW-1:0] ec;
            do_op(vt[i], lat, d);
            check("vec_latency", 32'(lat), 32'd2);
            check("vec_data", d, vt[i].exp);
            @(negedge clk);
            ec = CW'(i + 1);
            check("vec_op_count", 32'(op_count), 32'(ec));
        end
        wait_drain();

        // Operand isolation: live bus changes after grant must not reach the ALU
        @(posedge clk);
        #1;
        set_bus(0, 32'd3, 32'd3, EQ, 1'b0);
        bus.req_valid[0] = 1'b1;
        wait_grant(0);
        @(posedge clk);
        #1;
        bus.req_valid[0] = 1'b0;
        bus.req_a0 = 32'd9;
        bus.req_fun0 = SUB;
        wait_resp(0, lat, d);
        check("isolation_data", d, 32'd1);
        wait_drain();

        // Contention: both ports valid continuously, grants must alternate from port 0
        apply_reset();
        @(posedge clk);
        #1;
        set_bus(0, 32'd10, 32'd3, SUB, 1'b1);
        set_bus(1, 32'hF0F0F0F0, 32'h0FF0FFFF, AND, 1'b0);
        bus.req_valid = 2'b11;
        for (int n = 0; n < 60 && grant_log.size() < 6; n++) @(negedge clk);
        @(posedge clk);
        #1 bus.req_valid = 2'b00;
        wait_drain();
        check("contention_grants", 32'(grant_log.size()), 32'd6);
        for (int i = 0; i < grant_log.size() && i < 6; i++)
            check("contention_order", 32'(grant_log[i]), 32'(i % 2));

        // Backpressure on port 1 while port 0 waits
        apply_reset();
        @(posedge clk);
        #1;
        bus.resp_ready = 2'b01;
        set_bus(1, 32'd4, 32'd1, SLL, 1'b0);
        bus.req_valid[1] = 1'b1;
        wait_grant(1);
        @(posedge clk);
        #1;
        bus.req_valid[1] = 1'b0;
        set_bus(0, 32'd5, 32'd7, ADD, 1'b1);
        bus.req_valid[0] = 1'b1;
        wait_resp(1, lat, d);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_resp_valid", 32'(bus.resp_valid), 32'(2'b10));
            check("bp_resp_data", bus.resp_data, 32'd16);
            check("bp_req_ready", 32'(bus.req_ready), 32'd0);
        end
        @(posedge clk);
        #1 bus.resp_ready = 2'b11;
        @(negedge clk);
        check("bp_no_grant_consume", 32'(bus.req_ready), 32'd0);
        @(negedge clk);
        check("bp_next_grant", 32'(bus.req_ready), 32'(2'b01));
        @(posedge clk);
        #1 bus.req_valid[0] = 1'b0;
        wait_drain();

        // Reset mid-op in EXEC: aborted, no response afterwards
        apply_reset();
        @(posedge clk);
        #1;
        set_bus(0, 32'd1, 32'd2, ADD, 1'b0);
        bus.req_valid[0] = 1'b1;
        wait_grant(0);
        @(posedge clk);
        #1;
        bus.req_valid[0] = 1'b0;
        check("mid_busy_exec", 32'(busy), 32'd1);
        reset = 1'b0;
        #1;
        check("mid_rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("mid_no_stale_resp", 32'(bus.resp_valid), 32'd0);
        end
        check("mid_busy_after", 32'(busy), 32'd0);
        check("mid_op_count", 32'(op_count), 32'd0);
        do_op(vt[1], lat, d);
        check("mid_after_data", d, 32'd7);
        wait_drain();
        check("mid_after_count", 32'(op_count), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #300000;
        n_fail++;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected $finish");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
